// File: rtl/fixed_point_accumulator.sv
// Saturating fixed-point accumulator built around a carry-select adder.
// Consumes a programmed number of signed add/sub operands and returns the sum over valid/ready.

module carry_select_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         overflow_flag,
    output logic         negative
);
    localparam int NB = N / 2;

    logic [NB:0] carry;

    assign carry[0] = cin;

    // Each 2-bit slice precomputes both carry-in cases; the incoming carry selects one.
    for (genvar g = 0; g < NB; g++) begin : g_block
        logic [2:0] res0;
        logic [2:0] res1;

        assign res0 = {1'b0, a[2*g+1:2*g]} + {1'b0, b[2*g+1:2*g]};
        assign res1 = {1'b0, a[2*g+1:2*g]} + {1'b0, b[2*g+1:2*g]} + 3'd1;

        assign sum[2*g+1:2*g] = carry[g] ? res1[1:0] : res0[1:0];
        assign carry[g+1]     = carry[g] ? res1[2]   : res0[2];
    end

    // Sign of the infinite-precision result is the wrapped sign corrected by overflow.
    assign overflow_flag = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    assign negative      = sum[N-1] ^ overflow_flag;

endmodule

module fixed_point_accumulator #(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic [N-1:0]     init_value,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             in_sub,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     b_op;
    logic [N-1:0]     raw;
    logic [N-1:0]     sat_value;
    logic             ovf;
    logic             neg;
    logic             take;

    // Subtraction as A + ~D + 1 keeps 0x8000 exact through the carry-in.
    assign b_op = in_sub ? ~in_data : in_data;

    carry_select_adder #(.N(N)) u_adder (
        .a             (acc),
        .b             (b_op),
        .cin           (in_sub),
        .sum           (raw),
        .overflow_flag (ovf),
        .negative      (neg)
    );

    always_comb begin
        sat_value = raw;
        if (ovf) begin
            sat_value = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    assign take = (state == ACCUM) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (num_terms == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (take && (cnt == CNT_W'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                acc      <= init_value;
                cnt      <= num_terms;
                sat_flag <= 1'b0;
            end else if (take) begin
                acc      <= sat_value;
                cnt      <= cnt - CNT_W'(1);
                sat_flag <= sat_flag | ovf;
            end
        end
    end

    assign out_data = acc;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed and randomized checks of fixed_point_accumulator against an integer
// clamp-arithmetic reference model.

module tb_fixed_point_accumulator;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_terms;
    logic [15:0] init_value;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_sub;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        sat_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int m_acc;
    bit m_sat;

    fixed_point_accumulator #(.N(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_terms  (num_terms),
        .init_value (init_value),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sub     (in_sub),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact signed sum, clamped to the 16-bit two's-complement range.
    function automatic int model_step(input int a, input logic [15:0] d, input logic sub,
                                      output bit s);
        int sd;
        int r;
        sd = int'($signed(d));
        r  = sub ? a - sd : a + sd;
        s  = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(4))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'($urandom_range(15));
            3: return 16'hFFFF - 16'($urandom_range(15));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic do_start(input logic [15:0] init, input int n);
        m_acc      = int'($signed(init));
        m_sat      = 1'b0;
        start      = 1'b1;
        num_terms  = 8'(n);
        init_value = init;
        tick();
        start      = 1'b0;
        num_terms  = 8'($urandom);
        init_value = 16'($urandom);
        check("start_busy", 16'(busy), 16'd1);
        check("start_sat_clear", 16'(sat_flag), 16'd0);
        if (n == 0) begin
            check("zero_in_ready", 16'(in_ready), 16'd0);
            check("zero_out_valid", 16'(out_valid), 16'd1);
        end else begin
            check("start_in_ready", 16'(in_ready), 16'd1);
            check("start_out_valid", 16'(out_valid), 16'd0);
        end
    endtask

    task automatic feed(input logic [15:0] d, input logic sub);
        bit s;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        m_acc    = model_step(m_acc, d, sub, s);
        m_sat    = m_sat | s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input int hold, input bit poke);
        check("done_valid", 16'(out_valid), 16'd1);
        check("done_in_ready", 16'(in_ready), 16'd0);
        check("done_data", out_data, 16'(m_acc));
        check("done_sat", 16'(sat_flag), 16'(m_sat));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(1));
            in_data   = 16'($urandom);
            in_sub    = 1'($urandom_range(1));
            if (poke) begin
                start      = 1'($urandom_range(1));
                num_terms  = 8'($urandom);
                init_value = 16'($urandom);
            end
            tick();
            check("hold_valid", 16'(out_valid), 16'd1);
            check("hold_data", out_data, 16'(m_acc));
            check("hold_sat", 16'(sat_flag), 16'(m_sat));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = poke;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_valid", 16'(out_valid), 16'd0);
        check("idle_busy", 16'(busy), 16'd0);
        check("idle_sat_held", 16'(sat_flag), 16'(m_sat));
        check("idle_data_held", out_data, 16'(m_acc));
        tick();
        check("idle_busy_after", 16'(busy), 16'd0);
    endtask

    task automatic random_op(input int n, input int gap_pct, input bit poke, input int hold);
        int got;
        bit s;
        do_start(16'($urandom), n);
        got = 0;
        while (got < n) begin
            check("accum_ready", 16'(in_ready), 16'd1);
            check("accum_no_valid", 16'(out_valid), 16'd0);
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_sub   = 1'($urandom_range(1));
            end else begin
                in_valid = 1'b1;
                in_data  = rand_operand();
                in_sub   = 1'($urandom_range(1));
                m_acc    = model_step(m_acc, in_data, in_sub, s);
                m_sat    = m_sat | s;
                got++;
            end
            if (poke) begin
                start      = 1'($urandom_range(1));
                num_terms  = 8'($urandom);
                init_value = 16'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        finish_op(hold, poke);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        num_terms  = '0;
        init_value = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sub     = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 16'(in_ready), 16'd0);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_sat", 16'(sat_flag), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        tick();

        // Basic add with a subtract
        do_start(16'h0010, 3);
        feed(16'h0005, 1'b0);
        check("basic_mid_valid", 16'(out_valid), 16'd0);
        feed(16'h0003, 1'b0);
        check("basic_mid_valid2", 16'(out_valid), 16'd0);
        feed(16'h0002, 1'b1);
        check("basic_sum", out_data, 16'h0016);
        check("basic_sat", 16'(sat_flag), 16'd0);
        finish_op(0, 1'b0);

        // Positive saturation, then a fresh op clears the sticky flag
        do_start(16'h7FF0, 1);
        feed(16'h0020, 1'b0);
        check("possat_data", out_data, 16'h7FFF);
        check("possat_flag", 16'(sat_flag), 16'd1);
        finish_op(0, 1'b0);
        do_start(16'h0000, 1);
        feed(16'h0001, 1'b0);
        check("after_sat_data", out_data, 16'h0001);
        check("after_sat_flag", 16'(sat_flag), 16'd0);
        finish_op(0, 1'b0);

        // Negative saturation and subtract of the most negative value
        do_start(16'h8005, 1);
        feed(16'h0010, 1'b1);
        check("negsat_data", out_data, 16'h8000);
        check("negsat_flag", 16'(sat_flag), 16'd1);
        finish_op(0, 1'b0);
        do_start(16'h0000, 1);
        feed(16'h8000, 1'b1);
        check("submin_data", out_data, 16'h7FFF);
        check("submin_flag", 16'(sat_flag), 16'd1);
        finish_op(0, 1'b0);

        // Accumulation continues from the clamped value
        do_start(16'h7FF0, 2);
        feed(16'h0020, 1'b0);
        feed(16'h0001, 1'b1);
        check("clamp_continue", out_data, 16'h7FFE);
        check("clamp_flag", 16'(sat_flag), 16'd1);
        finish_op(0, 1'b0);

        // Handshake stress: gapped input, stalled output, stray starts
        random_op(5, 50, 1'b1, 10);

        // Zero terms, with in_valid asserted alongside start
        in_valid = 1'b1;
        in_data  = 16'h0101;
        do_start(16'h1234, 0);
        in_valid = 1'b0;
        check("zero_data", out_data, 16'h1234);
        finish_op(2, 1'b0);

        // Operand offered in IDLE is not consumed
        in_valid = 1'b1;
        in_data  = 16'h0777;
        tick();
        tick();
        in_valid = 1'b0;
        check("idle_operand_ignored", out_data, 16'h1234);
        check("idle_no_ready", 16'(in_ready), 16'd0);

        // Full-range term count
        do_start(16'h0000, 255);
        for (int i = 0; i < 255; i++) begin
            feed(16'h0001, 1'b0);
        end
        check("max_terms_data", out_data, 16'h00FF);
        finish_op(0, 1'b0);

        for (int op = 0; op < 24; op++) begin
            random_op(int'($urandom_range(1, 9)), int'($urandom_range(0, 60)),
                      1'($urandom_range(1)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of an accumulation
        do_start(16'h7FF0, 4);
        feed(16'h7FFF, 1'b0);
        feed(16'h7FFF, 1'b0);
        check("pre_reset_sat", 16'(sat_flag), 16'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 16'(in_ready), 16'd0);
        check("async_rst_data", out_data, 16'h0000);
        tick();
        check("midrst_in_ready", 16'(in_ready), 16'd0);
        check("midrst_out_valid", 16'(out_valid), 16'd0);
        check("midrst_data", out_data, 16'h0000);
        check("midrst_sat", 16'(sat_flag), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        tick();
        random_op(3, 20, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
